// File: rtl/exc_ctrl_pkg.sv
// Shared constants for the exception arbiter: exception codes, CP0 register
// addresses, Status bit positions and the arbiter's enumerated types.
package exc_ctrl_pkg;

  localparam logic [31:0] EXC_NONE = 32'h0;
  localparam logic [31:0] EXC_INT  = 32'h1;
  localparam logic [31:0] EXC_ADEL = 32'h4;
  localparam logic [31:0] EXC_ADES = 32'h5;
  localparam logic [31:0] EXC_SYS  = 32'h8;
  localparam logic [31:0] EXC_BP   = 32'h9;
  localparam logic [31:0] EXC_RI   = 32'hA;
  localparam logic [31:0] EXC_OV   = 32'hC;
  localparam logic [31:0] EXC_TR   = 32'hD;
  localparam logic [31:0] EXC_ERET = 32'hE;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_IM_HI = 15;
  localparam int ST_BEV   = 22;

  typedef enum logic {IDLE, FLUSH} exc_state_t;

  // Where BadVAddr comes from for the selected exception.
  typedef enum logic [1:0] {BAD_HOLD, BAD_PC, BAD_MEM} bad_src_t;

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchroniser for asynchronous interrupt lines, async active-low reset.
module irq_sync #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      dout <= '0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception arbiter between MEM and CP0: picks one exception by MIPS priority,
// registers the CP0 bundle and drives a timed flush with the redirect PC.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter logic [31:0] VEC_BEV      = 32'hBFC00380,
  parameter logic [31:0] VEC_NORM     = 32'h80000180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  input  logic        timer_int_i,
  input  logic        valid_i,
  input  logic        stall_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] mem_addr_i,
  input  logic        exc_adel_if_i,
  input  logic        exc_ri_i,
  input  logic        exc_sys_i,
  input  logic        exc_bp_i,
  input  logic        exc_ov_i,
  input  logic        exc_tr_i,
  input  logic        exc_adel_ld_i,
  input  logic        exc_ades_i,
  input  logic        eret_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_waddr_i,
  input  logic [31:0] cp0_wdata_i,
  output logic [31:0] excepttype_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] current_inst_addr_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  exc_state_t  state, state_next;
  logic [2:0]  flush_cnt;
  logic [5:0]  int_sync;
  logic [5:0]  hw;
  logic [31:0] eff_status;
  logic [1:0]  eff_cause_ip;
  logic [31:0] eff_epc;
  logic        int_pend;
  logic        take;
  logic        exc_hit;
  logic [31:0] exc_code;
  bad_src_t    bad_src;
  logic        is_eret;
  logic        unused_bits;

  irq_sync #(.WIDTH(6)) u_irq_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (int_i),
    .dout (int_sync)
  );

  assign hw = int_sync | {timer_int_i, 5'b0};

  // A CP0 write in this same cycle must be seen by the arbiter immediately.
  assign eff_status   = (cp0_we_i && cp0_waddr_i == CP0_STATUS) ? cp0_wdata_i : cp0_status_i;
  assign eff_cause_ip = (cp0_we_i && cp0_waddr_i == CP0_CAUSE) ? cp0_wdata_i[9:8] : cp0_cause_i[9:8];
  assign eff_epc      = (cp0_we_i && cp0_waddr_i == CP0_EPC) ? cp0_wdata_i : cp0_epc_i;

  assign int_pend = (|({hw, eff_cause_ip} & eff_status[ST_IM_HI:ST_IM_LO]))
                    & eff_status[ST_IE] & ~eff_status[ST_EXL];

  assign take    = valid_i & ~stall_i & (state == IDLE);
  assign exc_hit = take & (exc_code != EXC_NONE);

  assign unused_bits = ^{cp0_cause_i[31:10], cp0_cause_i[7:0], eff_status[31:23],
                         eff_status[21:16], eff_status[7:2]};

  always_comb begin
    exc_code = EXC_NONE;
    bad_src  = BAD_HOLD;
    is_eret  = 1'b0;
    if (int_pend)           exc_code = EXC_INT;
    else if (exc_adel_if_i) begin exc_code = EXC_ADEL; bad_src = BAD_PC; end
    else if (exc_ri_i)      exc_code = EXC_RI;
    else if (exc_sys_i)     exc_code = EXC_SYS;
    else if (exc_bp_i)      exc_code = EXC_BP;
    else if (exc_ov_i)      exc_code = EXC_OV;
    else if (exc_tr_i)      exc_code = EXC_TR;
    else if (exc_adel_ld_i) begin exc_code = EXC_ADEL; bad_src = BAD_MEM; end
    else if (exc_ades_i)    begin exc_code = EXC_ADES; bad_src = BAD_MEM; end
    else if (eret_i)        begin exc_code = EXC_ERET; is_eret = 1'b1; end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (exc_hit) state_next = FLUSH;
      FLUSH:   if (flush_cnt == 3'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    flush_o = (state == FLUSH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  flush_cnt <= 3'd0;
    else if (exc_hit)                          flush_cnt <= CNT_LOAD;
    else if (state == FLUSH && flush_cnt != 0) flush_cnt <= flush_cnt - 3'd1;
  end

  // excepttype pulses for one cycle; the rest of the bundle holds until the next take.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      excepttype_o        <= EXC_NONE;
      is_in_delayslot_o   <= 1'b0;
      current_inst_addr_o <= 32'h0;
      bad_addr_o          <= 32'h0;
      new_pc_o            <= 32'h0;
    end else begin
      excepttype_o <= exc_hit ? exc_code : EXC_NONE;
      if (exc_hit) begin
        is_in_delayslot_o   <= in_delayslot_i;
        current_inst_addr_o <= pc_i;
        new_pc_o            <= is_eret ? eff_epc : (eff_status[ST_BEV] ? VEC_BEV : VEC_NORM);
        case (bad_src)
          BAD_PC:  bad_addr_o <= pc_i;
          BAD_MEM: bad_addr_o <= mem_addr_i;
          default: bad_addr_o <= bad_addr_o;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: a behavioural model predicts each taken
// exception and the flush window; a monitor compares what the DUT presents.
module tb_exc_ctrl;

  localparam int FC = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  int_i;
  logic        timer_int_i, valid_i, stall_i, in_delayslot_i;
  logic [31:0] pc_i, mem_addr_i;
  logic        exc_adel_if_i, exc_ri_i, exc_sys_i, exc_bp_i, exc_ov_i, exc_tr_i;
  logic        exc_adel_ld_i, exc_ades_i, eret_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_wdata_i;
  logic        cp0_we_i;
  logic [4:0]  cp0_waddr_i;
  logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, new_pc_o;
  logic        is_in_delayslot_o, flush_o;

  typedef struct {
    logic [5:0]  intLines;
    logic        timer, valid, stall, ds;
    logic [31:0] pc, memAddr;
    logic        adelIf, ri, sys, bp, ov, tr, adelLd, ades, eret;
    logic [31:0] status, cause, epc, wdata;
    logic        we;
    logic [4:0]  waddr;
  } stim_t;

  typedef struct {
    logic [31:0] code, pc, bad;
    logic        ds;
    int unsigned due;
  } exp_t;

  stim_t       cur;
  exp_t        expQ[$];
  logic [5:0]  intHist[$];
  int unsigned cycle = 0;
  int          flushRem = 0;
  logic [31:0] mBad = 32'h0, mNewPc = 32'h0;
  logic        expFlush = 1'b0;
  int          compared = 0, mismatched = 0;

  exc_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .int_i(int_i), .timer_int_i(timer_int_i),
    .valid_i(valid_i), .stall_i(stall_i), .pc_i(pc_i), .in_delayslot_i(in_delayslot_i),
    .mem_addr_i(mem_addr_i), .exc_adel_if_i(exc_adel_if_i), .exc_ri_i(exc_ri_i),
    .exc_sys_i(exc_sys_i), .exc_bp_i(exc_bp_i), .exc_ov_i(exc_ov_i), .exc_tr_i(exc_tr_i),
    .exc_adel_ld_i(exc_adel_ld_i), .exc_ades_i(exc_ades_i), .eret_i(eret_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
    .cp0_we_i(cp0_we_i), .cp0_waddr_i(cp0_waddr_i), .cp0_wdata_i(cp0_wdata_i),
    .excepttype_o(excepttype_o), .is_in_delayslot_o(is_in_delayslot_o),
    .current_inst_addr_o(current_inst_addr_o), .bad_addr_o(bad_addr_o),
    .flush_o(flush_o), .new_pc_o(new_pc_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    int_i = s.intLines;       timer_int_i = s.timer;    valid_i = s.valid;
    stall_i = s.stall;        pc_i = s.pc;              in_delayslot_i = s.ds;
    mem_addr_i = s.memAddr;   exc_adel_if_i = s.adelIf; exc_ri_i = s.ri;
    exc_sys_i = s.sys;        exc_bp_i = s.bp;          exc_ov_i = s.ov;
    exc_tr_i = s.tr;          exc_adel_ld_i = s.adelLd; exc_ades_i = s.ades;
    eret_i = s.eret;          cp0_status_i = s.status;  cp0_cause_i = s.cause;
    cp0_epc_i = s.epc;        cp0_we_i = s.we;          cp0_waddr_i = s.waddr;
    cp0_wdata_i = s.wdata;
  endtask

  // Reference: interrupts seen two edges late, priority as an ordered list,
  // and a busy window of FC cycles after every taken exception.
  task automatic modelStep();
    logic [5:0]  seen;
    logic [31:0] st, epc;
    logic [1:0]  cip;
    logic        pending;
    logic        hits[10];
    logic [31:0] codes[10];
    seen = (intHist.size() >= 2) ? intHist[1] : 6'd0;
    intHist.push_front(int_i);
    if (intHist.size() > 2) void'(intHist.pop_back());
    st  = (cp0_we_i && cp0_waddr_i == 5'd12) ? cp0_wdata_i : cp0_status_i;
    cip = (cp0_we_i && cp0_waddr_i == 5'd13) ? cp0_wdata_i[9:8] : cp0_cause_i[9:8];
    epc = (cp0_we_i && cp0_waddr_i == 5'd14) ? cp0_wdata_i : cp0_epc_i;
    pending = ((({seen | {timer_int_i, 5'b0}, cip}) & st[15:8]) != 8'd0) && st[0] && !st[1];
    hits  = '{pending, exc_adel_if_i, exc_ri_i, exc_sys_i, exc_bp_i,
              exc_ov_i, exc_tr_i, exc_adel_ld_i, exc_ades_i, eret_i};
    codes = '{32'h1, 32'h4, 32'hA, 32'h8, 32'h9, 32'hC, 32'hD, 32'h4, 32'h5, 32'hE};
    if (flushRem > 0) begin
      flushRem--;
    end else if (valid_i && !stall_i) begin
      for (int k = 0; k < 10; k++) begin
        if (hits[k]) begin
          if (k == 1)           mBad = pc_i;
          if (k == 7 || k == 8) mBad = mem_addr_i;
          mNewPc = (k == 9) ? epc : (st[22] ? 32'hBFC0_0380 : 32'h8000_0180);
          expQ.push_back('{code: codes[k], pc: pc_i, bad: mBad, ds: in_delayslot_i, due: cycle});
          flushRem = FC;
          break;
        end
      end
    end
    expFlush = (flushRem > 0);
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (clk) cycle++;
    if (!rst) begin
      intHist  = {};
      expQ     = {};
      flushRem = 0;
      mBad     = 32'h0;
      mNewPc   = 32'h0;
      expFlush = 1'b0;
    end else begin
      modelStep();
    end
  end

  // Monitor: compares the flush window every cycle and pops a prediction
  // whenever the DUT presents an exception or one is due.
  initial forever begin
    logic dueNow;
    exp_t r;
    @(negedge clk);
    checkOutput("flush", 32'(flush_o), 32'(expFlush));
    if (expFlush) checkOutput("newPc", new_pc_o, mNewPc);
    dueNow = (expQ.size() > 0) && (expQ[0].due == cycle);
    checkOutput("excPresent", 32'(excepttype_o != 32'h0), 32'(dueNow));
    if (dueNow) begin
      r = expQ.pop_front();
      if (excepttype_o != 32'h0) begin
        checkOutput("excCode", excepttype_o, r.code);
        checkOutput("instAddr", current_inst_addr_o, r.pc);
        checkOutput("delaySlot", 32'(is_in_delayslot_o), 32'(r.ds));
        checkOutput("badAddr", bad_addr_o, r.bad);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cur = '{default: '0};
    cur.intLines = 6'h3F;
    applyStimulus(cur);
    applyStimulus(cur);
    checkOutput("rstExc", excepttype_o, 32'h0);
    checkOutput("rstFlush", 32'(flush_o), 32'h0);
    checkOutput("rstNewPc", new_pc_o, 32'h0);
    checkOutput("rstBad", bad_addr_o, 32'h0);
    checkOutput("rstAddr", current_inst_addr_o, 32'h0);
    checkOutput("rstDs", 32'(is_in_delayslot_o), 32'h0);
    applyStimulus(cur);
    rst = 1'b1;

    // Interrupts pending but no instruction: must not be taken.
    cur.status = 32'h0000_FC01;
    repeat (4) applyStimulus(cur);
    checkOutput("bubbleNoInt", excepttype_o, 32'h0);
    cur.intLines = 6'h0;
    cur.status = 32'h0;
    repeat (3) applyStimulus(cur);

    // Sys and RI together: RI wins, BEV vector.
    cur.valid = 1'b1; cur.sys = 1'b1; cur.ri = 1'b1;
    cur.pc = 32'h8000_0100; cur.status = 32'h0040_0000;
    applyStimulus(cur);
    cur.valid = 1'b0; cur.sys = 1'b0; cur.ri = 1'b0;
    applyStimulus(cur);
    checkOutput("riCode", excepttype_o, 32'h0A);
    checkOutput("riAddr", current_inst_addr_o, 32'h8000_0100);
    checkOutput("riFlush", 32'(flush_o), 32'h1);
    checkOutput("riVec", new_pc_o, 32'hBFC0_0380);
    repeat (3) applyStimulus(cur);
    checkOutput("riFlushDone", 32'(flush_o), 32'h0);

    // ERET picks up EPC written in the same cycle.
    cur.valid = 1'b1; cur.eret = 1'b1; cur.status = 32'h0; cur.epc = 32'h0000_1234;
    cur.we = 1'b1; cur.waddr = 5'd14; cur.wdata = 32'h8000_2000;
    applyStimulus(cur);
    cur.valid = 1'b0; cur.eret = 1'b0; cur.we = 1'b0;
    applyStimulus(cur);
    checkOutput("eretCode", excepttype_o, 32'h0E);
    checkOutput("eretPc", new_pc_o, 32'h8000_2000);
    repeat (3) applyStimulus(cur);

    // Interrupt through the synchroniser.
    cur.status = 32'h0000_0401; cur.valid = 1'b1; cur.intLines = 6'h01; cur.pc = 32'h8000_0200;
    applyStimulus(cur);
    applyStimulus(cur);
    applyStimulus(cur);
    checkOutput("intNotYet", excepttype_o, 32'h0);
    applyStimulus(cur);
    checkOutput("intCode", excepttype_o, 32'h1);
    checkOutput("intVec", new_pc_o, 32'h8000_0180);
    cur.valid = 1'b0; cur.intLines = 6'h0;
    repeat (4) applyStimulus(cur);

    // EXL masks the same interrupt.
    cur.status = 32'h0000_0403; cur.valid = 1'b1; cur.intLines = 6'h01;
    repeat (5) applyStimulus(cur);
    checkOutput("exlMasked", excepttype_o, 32'h0);
    cur.valid = 1'b0; cur.intLines = 6'h0; cur.status = 32'h0;
    repeat (3) applyStimulus(cur);

    // AdES held under stall, taken once stall drops.
    cur.valid = 1'b1; cur.ades = 1'b1; cur.memAddr = 32'h8000_0003; cur.stall = 1'b1;
    applyStimulus(cur);
    applyStimulus(cur);
    checkOutput("stall1", excepttype_o, 32'h0);
    applyStimulus(cur);
    checkOutput("stall2", excepttype_o, 32'h0);
    cur.stall = 1'b0;
    applyStimulus(cur);
    checkOutput("stall3", excepttype_o, 32'h0);
    cur.valid = 1'b0; cur.ades = 1'b0;
    applyStimulus(cur);
    checkOutput("adesCode", excepttype_o, 32'h5);
    checkOutput("adesBad", bad_addr_o, 32'h8000_0003);
    repeat (3) applyStimulus(cur);

    // Back-to-back Ov: lockout for FC cycles, then reset mid-flush.
    cur.valid = 1'b1; cur.ov = 1'b1; cur.pc = 32'h8000_0400;
    applyStimulus(cur);
    applyStimulus(cur);
    checkOutput("ov1Code", excepttype_o, 32'h0C);
    checkOutput("ov1Flush", 32'(flush_o), 32'h1);
    applyStimulus(cur);
    checkOutput("ovLocked", excepttype_o, 32'h0);
    applyStimulus(cur);
    checkOutput("ovFlush3", 32'(flush_o), 32'h1);
    applyStimulus(cur);
    checkOutput("ovFlushEnd", 32'(flush_o), 32'h0);
    applyStimulus(cur);
    checkOutput("ov2Code", excepttype_o, 32'h0C);
    #2 rst = 1'b0;
    #1 checkOutput("rstMidFlush", 32'(flush_o), 32'h0);
    checkOutput("rstMidExc", excepttype_o, 32'h0);
    cur.valid = 1'b0; cur.ov = 1'b0;
    applyStimulus(cur);
    rst = 1'b1;
    repeat (2) applyStimulus(cur);

    // Randomised traffic against the model.
    for (int i = 0; i < 500; i++) begin
      cur.valid   = ($urandom_range(0, 3) != 0);
      cur.stall   = ($urandom_range(0, 4) == 0);
      cur.pc      = $urandom;
      cur.ds      = 1'($urandom_range(0, 1));
      cur.memAddr = $urandom;
      cur.adelIf  = ($urandom_range(0, 15) == 0);
      cur.ri      = ($urandom_range(0, 15) == 0);
      cur.sys     = ($urandom_range(0, 15) == 0);
      cur.bp      = ($urandom_range(0, 15) == 0);
      cur.ov      = ($urandom_range(0, 15) == 0);
      cur.tr      = ($urandom_range(0, 15) == 0);
      cur.adelLd  = ($urandom_range(0, 15) == 0);
      cur.ades    = ($urandom_range(0, 15) == 0);
      cur.eret    = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) cur.intLines = 6'($urandom);
      cur.timer   = ($urandom_range(0, 15) == 0);
      cur.status  = $urandom & 32'h0040_FF01;
      if ($urandom_range(0, 3) == 0) cur.status[1] = 1'b1;
      cur.cause   = $urandom;
      cur.epc     = $urandom;
      cur.we      = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       cur.waddr = 5'd12;
        1:       cur.waddr = 5'd13;
        2:       cur.waddr = 5'd14;
        default: cur.waddr = 5'($urandom);
      endcase
      cur.wdata   = $urandom;
      applyStimulus(cur);
    end

    cur = '{default: '0};
    repeat (10) applyStimulus(cur);
    checkOutput("pendingAtEnd", 32'(expQ.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
